// File: rtl/vga_pixel_fetch_pkg.sv
// rtl/vga_pixel_fetch_pkg.sv - shared VGA timing constants and pixel tag type
// Purpose: window placement and frame totals shared with VGA_controller (both
//          must use the same values), plus the tag that travels alongside a
//          video RAM read until its data returns.
package vga_pixel_fetch_pkg;

    localparam int H_START  = 242;
    localparam int V_START  = 142;
    localparam int WIN_SIZE = 256;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 521;
    localparam int RGB_W    = 3;

    // Everything the output mux needs besides the RAM word itself.
    typedef struct packed {
        logic             win;
        logic             hit;
        logic [RGB_W-1:0] color;
    } pix_tag_t;

endpackage

// File: rtl/vga_pixel_fetch_pipe_delay.sv
// rtl/vga_pixel_fetch_pipe_delay.sv - fixed-depth register delay line
// Purpose: delays a WIDTH-bit word by DEPTH clock cycles (DEPTH >= 1), each
//          stage a synchronously reset, always-enabled flop.
// Ports:
//   Clock  in   1      clock
//   Reset  in   1      synchronous, active-high; clears every stage
//   iData  in   WIDTH  word entering the line
//   oData  out  WIDTH  word leaving the line, DEPTH cycles later
module vga_pixel_fetch_pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] iData,
    output logic [WIDTH-1:0] oData
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= iData;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign oData = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - VGA image prefetch with cursor overlay
// Purpose: runs the video RAM address LEAD pixels ahead of the VGA counters so
//          that the 256x256 image (with a solid cursor square on top) arrives
//          in oRGB exactly in the cycle its counter value is shown.
// Ports:
//   Clock        in   1   pixel clock
//   Reset        in   1   synchronous, active-high
//   iHcounter    in   10  horizontal count
//   iVcounter    in   10  vertical count
//   oRamAddr     out  16  video RAM address {y, x}, registered
//   iRamData     in   3   RAM word, RD_LAT cycles after oRamAddr
//   iCurX/iCurY  in   8   cursor top-left, window coordinates
//   iCurColor    in   3   cursor colour
//   iCurEnable   in   1   cursor drawn when 1
//   oRGB         out  3   pixel colour, registered
//   oFrameStart  out  1   pulse in the cycle after counters read (0,0)
module vga_pixel_fetch
    import vga_pixel_fetch_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int CUR_SIZE = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [9:0]       iHcounter,
    input  logic [9:0]       iVcounter,
    output logic [15:0]      oRamAddr,
    input  logic [RGB_W-1:0] iRamData,
    input  logic [7:0]       iCurX,
    input  logic [7:0]       iCurY,
    input  logic [RGB_W-1:0] iCurColor,
    input  logic             iCurEnable,
    output logic [RGB_W-1:0] oRGB,
    output logic             oFrameStart
);

    // One cycle for the address register, RD_LAT for the RAM, one for oRGB.
    localparam int LEAD = RD_LAT + 2;

    logic [7:0]       r_cur_x;
    logic [7:0]       r_cur_y;
    logic [RGB_W-1:0] r_cur_color;
    logic             r_cur_en;
    pix_tag_t         r_tag_a;
    pix_tag_t         w_tag_d;

    logic [10:0] w_hf;
    logic [10:0] w_x_full;
    logic [9:0]  w_y_full;
    logic [7:0]  w_x;
    logic [7:0]  w_y;
    logic        w_win;
    logic        w_hit_x;
    logic        w_hit_y;
    logic        w_hit;
    logic        w_frame_origin;

    // Fetch coordinate is 11 bits wide so H near the line end cannot wrap back
    // into the window. Coordinates left of / above the window underflow to
    // large unsigned values and fail the < WIN_SIZE test.
    assign w_hf     = {1'b0, iHcounter} + 11'(LEAD);
    assign w_x_full = w_hf - 11'(H_START);
    assign w_y_full = iVcounter - 10'(V_START);
    assign w_x      = w_x_full[7:0];
    assign w_y      = w_y_full[7:0];

    assign w_win = (w_hf < 11'(H_TOTAL)) && (iVcounter < 10'(V_TOTAL)) &&
                   (w_x_full < 11'(WIN_SIZE)) && (w_y_full < 10'(WIN_SIZE));

    // 9-bit compares: a square reaching past 255 is clipped rather than
    // reappearing at coordinate 0.
    assign w_hit_x = ({1'b0, w_x} >= {1'b0, r_cur_x}) &&
                     ({1'b0, w_x} <  ({1'b0, r_cur_x} + 9'(CUR_SIZE)));
    assign w_hit_y = ({1'b0, w_y} >= {1'b0, r_cur_y}) &&
                     ({1'b0, w_y} <  ({1'b0, r_cur_y} + 9'(CUR_SIZE)));
    assign w_hit   = r_cur_en && w_hit_x && w_hit_y;

    assign w_frame_origin = (iHcounter == 10'd0) && (iVcounter == 10'd0);

    // Cursor parameters only change at the frame origin so a frame is never
    // drawn with two cursor positions.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_cur_color <= '0;
            r_cur_en    <= 1'b0;
        end else if (w_frame_origin) begin
            r_cur_x     <= iCurX;
            r_cur_y     <= iCurY;
            r_cur_color <= iCurColor;
            r_cur_en    <= iCurEnable;
        end
    end

    // Stage A: address out to RAM, tag captured alongside it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oRamAddr <= '0;
            r_tag_a  <= '0;
        end else begin
            if (w_win) begin
                oRamAddr <= {w_y, w_x};
            end
            r_tag_a.win   <= w_win;
            r_tag_a.hit   <= w_hit;
            r_tag_a.color <= r_cur_color;
        end
    end

    vga_pixel_fetch_pipe_delay #(
        .WIDTH ($bits(pix_tag_t)),
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .Clock (Clock),
        .Reset (Reset),
        .iData (r_tag_a),
        .oData (w_tag_d)
    );

    // Stage B: tag and RAM word now refer to the same pixel.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oRGB        <= '0;
            oFrameStart <= 1'b0;
        end else begin
            if (!w_tag_d.win) begin
                oRGB <= '0;
            end else if (w_tag_d.hit) begin
                oRGB <= w_tag_d.color;
            end else begin
                oRGB <= iRamData;
            end
            oFrameStart <= w_frame_origin;
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - scoreboard bench for vga_pixel_fetch at RD_LAT 1, 2, 4
module tb_vga_pixel_fetch;

    localparam int CUR_SIZE = 8;

    typedef struct packed {
        logic [2:0][2:0]  rgb;
        logic [2:0][15:0] addr;
        logic             fs;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [7:0]  cur_x;
    logic [7:0]  cur_y;
    logic [2:0]  cur_color;
    logic        cur_en;

    logic [2:0][15:0] addr_p;
    logic [2:0][2:0]  rgb_p;
    logic [2:0]       fs_p;
    logic [2:0]       ram1;
    logic [2:0]       ram2 [2];
    logic [2:0]       ram4 [4];

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Golden-model state
    int          m_cx = 0, m_cy = 0, m_col = 0;
    logic        m_en = 1'b0;
    logic [15:0] m_addr [3];
    int          quiet  [3];

    always #5 Clock = ~Clock;

    vga_pixel_fetch #(.RD_LAT(1), .CUR_SIZE(CUR_SIZE)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .iHcounter(hcnt), .iVcounter(vcnt),
        .oRamAddr(addr_p[0]), .iRamData(ram1), .iCurX(cur_x), .iCurY(cur_y),
        .iCurColor(cur_color), .iCurEnable(cur_en), .oRGB(rgb_p[0]), .oFrameStart(fs_p[0]));

    vga_pixel_fetch #(.RD_LAT(2), .CUR_SIZE(CUR_SIZE)) u_dut2 (
        .Clock(Clock), .Reset(Reset), .iHcounter(hcnt), .iVcounter(vcnt),
        .oRamAddr(addr_p[1]), .iRamData(ram2[1]), .iCurX(cur_x), .iCurY(cur_y),
        .iCurColor(cur_color), .iCurEnable(cur_en), .oRGB(rgb_p[1]), .oFrameStart(fs_p[1]));

    vga_pixel_fetch #(.RD_LAT(4), .CUR_SIZE(CUR_SIZE)) u_dut4 (
        .Clock(Clock), .Reset(Reset), .iHcounter(hcnt), .iVcounter(vcnt),
        .oRamAddr(addr_p[2]), .iRamData(ram4[3]), .iCurX(cur_x), .iCurY(cur_y),
        .iCurColor(cur_color), .iCurEnable(cur_en), .oRGB(rgb_p[2]), .oFrameStart(fs_p[2]));

    function automatic logic [2:0] ram_word(logic [15:0] a);
        return a[2:0] ^ a[10:8];
    endfunction

    // Behavioural video RAMs, latency 1, 2 and 4
    always @(posedge Clock) begin
        ram1    <= ram_word(addr_p[0]);
        ram2[0] <= ram_word(addr_p[1]);
        ram2[1] <= ram2[0];
        ram4[0] <= ram_word(addr_p[2]);
        for (int i = 1; i < 4; i++) ram4[i] <= ram4[i-1];
    end

    function automatic int lead_of(int d);
        return (d == 0) ? 3 : (d == 1) ? 4 : 6;
    endfunction

    function automatic logic in_win(int x, int y);
        return (x >= 242) && (x < 498) && (y >= 142) && (y < 398);
    endfunction

    // Expected pixel for the counter value currently on screen
    function automatic logic [2:0] pix(int h, int v);
        int x, y;
        x = h - 242;
        y = v - 142;
        if (!in_win(h, v)) return 3'd0;
        if (m_en && x >= m_cx && x < m_cx + CUR_SIZE && y >= m_cy && y < m_cy + CUR_SIZE)
            return 3'(m_col);
        return 3'(x[2:0] ^ y[2:0]);
    endfunction

    // Drive one counter value for one cycle and queue the expected outputs.
    task automatic step(input int h, input int v, input logic r);
        int p_h, p_v, hf;
        logic p_r, p_en;
        logic [7:0] p_cx, p_cy;
        logic [2:0] p_col;
        exp_t e;
        p_h = int'(hcnt); p_v = int'(vcnt); p_r = Reset;
        p_cx = cur_x; p_cy = cur_y; p_col = cur_color; p_en = cur_en;
        @(posedge Clock);
        #1;
        if (p_r) begin
            m_en = 1'b0; m_cx = 0; m_cy = 0; m_col = 0;
            for (int d = 0; d < 3; d++) begin
                m_addr[d] = 16'h0000;
                quiet[d]  = lead_of(d);
            end
        end else begin
            if (p_h == 0 && p_v == 0) begin
                m_cx = int'(p_cx); m_cy = int'(p_cy); m_col = int'(p_col); m_en = p_en;
            end
            for (int d = 0; d < 3; d++) begin
                hf = p_h + lead_of(d);
                if (in_win(hf, p_v)) m_addr[d] = {8'(p_v - 142), 8'(hf - 242)};
            end
        end
        e.fs = !p_r && p_h == 0 && p_v == 0;
        hcnt  = 10'(h);
        vcnt  = 10'(v);
        Reset = r;
        for (int d = 0; d < 3; d++) begin
            e.rgb[d]  = (quiet[d] > 0) ? 3'd0 : pix(h, v);
            e.addr[d] = m_addr[d];
            if (quiet[d] > 0) quiet[d]--;
        end
        sb.push_back(e);
    endtask

    task automatic check(input string name, input int lat, input logic [15:0] act,
                         input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s lat=%0d h=%0d v=%0d actual=%0h required=%0h",
                     name, lat, hcnt, vcnt, act, req);
        end
    endtask

    // Monitor: one expected entry per cycle, compared on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int d = 0; d < 3; d++) begin
                    check("rgb",  (d == 2) ? 4 : d + 1, 16'(rgb_p[d]), 16'(e.rgb[d]));
                    check("addr", (d == 2) ? 4 : d + 1, addr_p[d], e.addr[d]);
                    check("frame_start", (d == 2) ? 4 : d + 1, 16'(fs_p[d]), 16'(e.fs));
                end
            end
        end
    end

    int lines [15] = '{0, 10, 11, 17, 18, 141, 142, 143, 200, 201, 207, 208, 396, 397, 398};

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_addr[d] = 16'h0000;
            quiet[d]  = 0;
        end
        Reset = 1'b1; hcnt = '0; vcnt = '0;
        cur_x = 8'd250; cur_y = 8'd10; cur_color = 3'b100; cur_en = 1'b1;
        repeat (4) step(0, 0, 1'b1);

        // Frame 0: cursor clipped at the right edge (y 10..17).
        // Frame 1: cursor at (20,200), moved to x=40 mid-frame.
        // Frame 2: mid-line reset clears the cursor for the rest of the frame.
        // Frame 3: cursor at (40,200).
        for (int f = 0; f < 4; f++) begin
            foreach (lines[li]) begin
                for (int h = 0; h < 800; h++) begin
                    if (f == 0 && lines[li] == 200 && h == 0) begin
                        cur_x = 8'd20; cur_y = 8'd200; cur_color = 3'b010;
                    end
                    if (f == 1 && lines[li] == 200 && h == 0) cur_x = 8'd40;
                    step(h, lines[li], (f == 2 && lines[li] == 142 && h >= 300 && h < 305));
                end
            end
        end

        // Out-of-range counters
        for (int i = 0; i < 10; i++) step(900 + i, 600, 1'b0);

        @(posedge Clock);
        @(negedge Clock);
        @(negedge Clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
